// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state type, data width, counter sizing helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  // Shared by uart_tx and uart_rx so both walk the same frame phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int UART_DATA_BITS = 8;

  // Width of a down-counter that must hold values up to clks.
  function automatic int uart_cnt_bits(input int clks);
    return $clog2(clks + 1);
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, with a one-entry holding register ahead of the shifter.
// Latency: accept at edge N drives the start bit from edge N+1; each bit lasts CLKS_PER_BIT cycles.
// Backpressure: o_tx_ready is low while the holding register is full; a queued byte starts
//               the cycle after o_tx_done, so back-to-back frames have no idle gap.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   i_tx_valid/i_tx_data  byte producer handshake (data sampled only on the accept edge)
//   o_tx_ready            holding register empty
//   o_tx_busy             a frame is on the line
//   o_tx_done             one-cycle pulse in the last cycle of each stop bit
//   o_tx_data             registered serial line, idles high
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_tx_valid,
  input  logic [UART_DATA_BITS-1:0] i_tx_data,
  output logic                      o_tx_ready,
  output logic                      o_tx_busy,
  output logic                      o_tx_done,
  output logic                      o_tx_data
);

  localparam int               CNT_W      = uart_cnt_bits(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [2:0]       LAST_BIT   = 3'(UART_DATA_BITS - 1);

  uart_state_t               state_q, state_d;
  logic [CNT_W-1:0]          clk_cnt_q, clk_cnt_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] hold_data_q, hold_data_d;
  logic                      hold_valid_q, hold_valid_d;
  logic                      tx_q, tx_d;

  logic       accept;
  logic       cnt_zero;
  logic       load_hold;
  logic [2:0] next_bit;

  assign accept   = i_tx_valid && !hold_valid_q;
  assign cnt_zero = (clk_cnt_q == '0);
  assign next_bit = bit_cnt_q + 3'd1;

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
    tx_d         = tx_q;
    load_hold    = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (hold_valid_q) begin
          load_hold = 1'b1;
        end
      end

      START: begin
        if (cnt_zero) begin
          tx_d      = shift_q[0];
          bit_cnt_d = 3'd0;
          clk_cnt_d = CNT_RELOAD;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q - CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_zero) begin
          clk_cnt_d = CNT_RELOAD;
          // Decide on the last bit index so the 3-bit counter never wraps.
          if (bit_cnt_q == LAST_BIT) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_cnt_d = next_bit;
            tx_d      = shift_q[next_bit];
          end
        end else begin
          clk_cnt_d = clk_cnt_q - CNT_ONE;
        end
      end

      STOP: begin
        if (cnt_zero) begin
          // A queued byte chains straight into its start bit.
          if (hold_valid_q) begin
            load_hold = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (load_hold) begin
      shift_d      = hold_data_q;
      hold_valid_d = 1'b0;
      tx_d         = 1'b0;
      clk_cnt_d    = CNT_RELOAD;
      state_d      = START;
    end

    // Accept only happens with the holding register empty, so it can never
    // collide with load_hold on the same edge.
    if (accept) begin
      hold_data_d  = i_tx_data;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      hold_data_q  <= '0;
      hold_valid_q <= 1'b0;
      tx_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      hold_data_q  <= hold_data_d;
      hold_valid_q <= hold_valid_d;
      tx_q         <= tx_d;
    end
  end

  assign o_tx_ready = !hold_valid_q;
  assign o_tx_busy  = (state_q != IDLE);
  assign o_tx_done  = (state_q == STOP) && cnt_zero;
  assign o_tx_data  = tx_q;

endmodule
